program_loader: RTL and testbench

//  Boot-time stage upstream of the uCISC cpu. Takes a byte stream (UART/debug link) framed as load records.

---
 rtl/ucisc_loader_pkg.sv | 25 ++
 rtl/loader_timeout_counter.sv | 34 +++
 rtl/program_loader.sv | 193 +++++++++++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ucisc_loader_pkg.sv
// ucisc_loader_pkg: shared definitions for the uCISC program loader.
//   loader_state_t     : record-parsing FSM states
//   SYNC_BYTE_DEFAULT  : default record start byte
//   BYTE_W / WORD_W    : stream byte and memory word widths
package ucisc_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    ST_SYNC    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_CNT_HI  = 4'd3,
    ST_CNT_LO  = 4'd4,
    ST_DATA_HI = 4'd5,
    ST_DATA_LO = 4'd6,
    ST_CHK     = 4'd7,
    ST_BOOT    = 4'd8,
    ST_DONE    = 4'd9
  } loader_state_t;

endpackage

// File: rtl/loader_timeout_counter.sv
// loader_timeout_counter: counts idle clocks between accepted bytes.
//   clock_input : system clock
//   reset       : asynchronous active-low reset
//   clear       : a byte was accepted this cycle; restart the count
//   enable      : loader is inside a record; count while high
//   expired     : high on the cycle whose edge would be the LIMIT-th idle clock
module loader_timeout_counter #(
  parameter int LIMIT = 1024
) (
  input  logic clock_input,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // The count holds the idle clocks already seen; this edge is the LIMIT-th.
  assign expired = enable && !clear && (count == CW'(LIMIT - 1));

  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || !enable || expired) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: boot-time loader in front of the uCISC cpu.
// Parses records  SYNC ADDR_HI ADDR_LO CNT_HI CNT_LO {DATA_HI DATA_LO}*CNT [CHK]
// and writes big-endian words to cpu memory. A record with CNT=0 releases the cpu.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing 8-bit sum byte).
// Ports:
//   clock_input, reset (async active-low)
//   byte_data/byte_valid/byte_ready : byte stream in
//   mem_write_enable/address/data   : one-cycle registered write port
//   cpu_hold     : 1 keeps cpu in reset
//   loader_busy  : inside a record
//   frame_error  : one-cycle pulse on timeout or checksum mismatch
//   words_loaded : words written since reset
//   loader_state : current FSM state (observability)
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
// byte_ready does not depend on byte_valid.
module program_loader
  import ucisc_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                clock_input,
  input  logic                reset,
  input  logic [BYTE_W-1:0]   byte_data,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic                mem_write_enable,
  output logic [WORD_W-1:0]   mem_write_address,
  output logic [WORD_W-1:0]   mem_write_data,
  output logic                cpu_hold,
  output logic                loader_busy,
  output logic                frame_error,
  output logic [WORD_W-1:0]   words_loaded,
  output loader_state_t       loader_state
);

  loader_state_t state, state_next;

  logic              accept;
  logic              we_set;
  logic              fe_set;
  logic              timeout_expired;
  logic [BYTE_W-1:0] hi_byte;     // holds ADDR_HI, CNT_HI or DATA_HI
  logic [WORD_W-1:0] cur_addr;    // address of the next word to write
  logic [WORD_W-1:0] remaining;   // words still to come in this record
  logic [WORD_W-1:0] joined;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum;
  logic              boot_rec;
`endif

  assign byte_ready   = (state != ST_DONE);
  assign loader_busy  = (state != ST_SYNC) && (state != ST_DONE);
  assign accept       = byte_valid && byte_ready;
  assign joined       = {hi_byte, byte_data};
  assign loader_state = state;

  loader_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock_input (clock_input),
    .reset       (reset),
    .clear       (accept),
    .enable      (loader_busy),
    .expired     (timeout_expired)
  );

  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      state <= ST_SYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    we_set     = 1'b0;
    fe_set     = 1'b0;
    case (state)
      ST_SYNC:    if (accept && byte_data == SYNC_BYTE) state_next = ST_ADDR_HI;
      ST_ADDR_HI: if (accept) state_next = ST_ADDR_LO;
      ST_ADDR_LO: if (accept) state_next = ST_CNT_HI;
      ST_CNT_HI:  if (accept) state_next = ST_CNT_LO;
      ST_CNT_LO: begin
        if (accept) begin
          if (joined == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_next = ST_CHK;
`else
            state_next = ST_BOOT;
`endif
          end else begin
            state_next = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: if (accept) state_next = ST_DATA_LO;
      ST_DATA_LO: begin
        if (accept) begin
          we_set = 1'b1;
          if (remaining == WORD_W'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_next = ST_CHK;
`else
            state_next = ST_SYNC;
`endif
          end else begin
            state_next = ST_DATA_HI;
          end
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          if (byte_data == sum) begin
            state_next = boot_rec ? ST_BOOT : ST_SYNC;
          end else begin
            fe_set     = 1'b1;
            state_next = ST_SYNC;
          end
        end
      end
`endif
      ST_BOOT: state_next = ST_DONE;
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_SYNC;
    endcase
    // Expiry is gated by "no byte accepted", so it never competes with a write.
    if (timeout_expired) begin
      state_next = ST_SYNC;
      fe_set     = 1'b1;
    end
  end

  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      mem_write_enable  <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      cpu_hold          <= 1'b1;
      frame_error       <= 1'b0;
      words_loaded      <= '0;
      hi_byte           <= '0;
      cur_addr          <= '0;
      remaining         <= '0;
    end else begin
      mem_write_enable <= we_set;
      frame_error      <= fe_set;
      if (we_set) begin
        mem_write_address <= cur_addr;
        mem_write_data    <= joined;
        cur_addr          <= cur_addr + WORD_W'(1);
        remaining         <= remaining - WORD_W'(1);
        words_loaded      <= words_loaded + WORD_W'(1);
      end
      if (accept) begin
        case (state)
          ST_ADDR_HI, ST_CNT_HI, ST_DATA_HI: hi_byte <= byte_data;
          ST_ADDR_LO: cur_addr  <= joined;
          ST_CNT_LO:  remaining <= joined;
          default: ;
        endcase
      end
      // cpu leaves reset the cycle after the FSM settles in DONE.
      if (state == ST_DONE) begin
        cpu_hold <= 1'b0;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      sum      <= '0;
      boot_rec <= 1'b0;
    end else if (accept) begin
      case (state)
        ST_SYNC: sum <= '0;
        ST_ADDR_HI, ST_ADDR_LO, ST_CNT_HI, ST_DATA_HI, ST_DATA_LO:
          sum <= sum + byte_data;
        ST_CNT_LO: begin
          sum      <= sum + byte_data;
          boot_rec <= (joined == '0);
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
// Expected memory writes are queued when a record is driven and compared
// by a monitor each time the write strobe appears.
module tb_program_loader;
  import ucisc_loader_pkg::*;

  localparam int TO = 1024;

  logic              clock_input;
  logic              reset;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_write_enable;
  logic [15:0]       mem_write_address;
  logic [15:0]       mem_write_data;
  logic              cpu_hold;
  logic              loader_busy;
  logic              frame_error;
  logic [15:0]       words_loaded;
  loader_state_t     loader_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  rec_q[$];
  logic [15:0] exp_wl = 16'h0000;

  program_loader #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock_input       (clock_input),
    .reset             (reset),
    .byte_data         (byte_data),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .cpu_hold          (cpu_hold),
    .loader_busy       (loader_busy),
    .frame_error       (frame_error),
    .words_loaded      (words_loaded),
    .loader_state      (loader_state)
  );

  // clock / reset
  initial clock_input = 1'b0;
  always #5 clock_input = ~clock_input;

  // scoreboard monitor
  always @(negedge clock_input) begin
    if (reset === 1'b1 && mem_write_enable === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write got=%h:%h expected=none", mem_write_address, mem_write_data);
      end
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({mem_write_address, mem_write_data} === e) else begin
          failures++;
          $error("FAIL write got=%h:%h expected=%h:%h", mem_write_address, mem_write_data,
                 e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
    exp_wl = exp_wl + 16'h1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_input);
      #1;
    end
  endtask

  // driver: byte presented before the edge, edge transfers it
  task automatic send_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(posedge clock_input);
    #1;
  endtask

  // sends rec_q back-to-back; appends the checksum byte when the feature is built
  task automatic send_rec(input bit with_chk, input bit bad_chk);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < rec_q.size(); i++) begin
      if (i > 0) s = s + rec_q[i];
      send_byte(rec_q[i]);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (with_chk) send_byte(bad_chk ? s + 8'h01 : s);
`else
    if (with_chk && bad_chk) s = s + 8'h01;
`endif
    byte_valid = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // 1: reset
    cycles(2);
    @(negedge clock_input);
    reset = 1'b1;
    #1;
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_byte_ready", byte_ready, 1);
    check("rst_busy", loader_busy, 0);
    check("rst_we", mem_write_enable, 0);
    check("rst_addr_data", {mem_write_address, mem_write_data}, 0);
    check("rst_words", words_loaded, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_state", loader_state, ST_SYNC);
    cycles(3);

    // junk while hunting is discarded
    send_byte(8'h12);
    send_byte(8'h00);
    byte_valid = 1'b0;
    check("hunt_state", loader_state, ST_SYNC);

    // 2: two-word record
    expect_write(16'h0010, 16'h1234);
    expect_write(16'h0011, 16'hABCD);
    rec_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_rec(1, 0);
    check("t2_frame_error", frame_error, 0);
    cycles(3);
    check("t2_words", words_loaded, exp_wl);
    check("t2_state", loader_state, ST_SYNC);
    check("t2_queue_empty", exp_q.size(), 0);

    // 4: timeout after DATA_HI
    rec_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h56};
    send_rec(0, 0);
    check("t4_busy", loader_busy, 1);
    n = 0;
    seen = 0;
    for (int i = 1; i <= TO + 20; i++) begin
      cycles(1);
      if (frame_error === 1'b1) begin
        n = i;
        seen = 1;
        break;
      end
    end
    check("t4_timeout_seen", seen, 1);
    check("t4_timeout_cycles", n, TO);
    check("t4_state", loader_state, ST_SYNC);
    cycles(1);
    check("t4_pulse_one_cycle", frame_error, 0);
    check("t4_words", words_loaded, exp_wl);
    expect_write(16'h0040, 16'h9988);
    rec_q = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'h99, 8'h88};
    send_rec(1, 0);
    cycles(3);
    check("t4_next_words", words_loaded, exp_wl);

    // 5: address wrap
    expect_write(16'hFFFF, 16'h1111);
    expect_write(16'h0000, 16'h2222);
    rec_q = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
    send_rec(1, 0);
    cycles(3);
    check("t5_words", words_loaded, exp_wl);
    check("t5_queue_empty", exp_q.size(), 0);

    // SYNC byte inside data is plain data
    expect_write(16'h0100, 16'hA5A5);
    rec_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'hA5, 8'hA5};
    send_rec(1, 0);
    cycles(3);
    check("sync_as_data_words", words_loaded, exp_wl);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // 6: bad checksum on data record keeps writes, pulses frame_error
    expect_write(16'h0010, 16'h1234);
    expect_write(16'h0011, 16'hABCD);
    rec_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_rec(1, 1);
    check("t6_frame_error", frame_error, 1);
    cycles(3);
    check("t6_words", words_loaded, exp_wl);
    // bad checksum on boot record: no boot
    rec_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    send_rec(1, 1);
    check("t6_boot_frame_error", frame_error, 1);
    cycles(4);
    check("t6_boot_cpu_hold", cpu_hold, 1);
    check("t6_boot_state", loader_state, ST_SYNC);
`endif

    // reset mid-record after DATA_HI
    rec_q = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'h77};
    send_rec(0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_cpu_hold", cpu_hold, 1);
    check("mid_rst_we", mem_write_enable, 0);
    cycles(2);
    @(negedge clock_input);
    reset = 1'b1;
    exp_wl = 16'h0000;
    cycles(2);
    check("mid_rst_state", loader_state, ST_SYNC);
    check("mid_rst_words", words_loaded, exp_wl);

    // 3: boot record
    rec_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    send_rec(1, 0);
    check("t3_boot_state", loader_state, ST_BOOT);
    check("t3_hold_in_boot", cpu_hold, 1);
    cycles(1);
    check("t3_done_state", loader_state, ST_DONE);
    check("t3_hold_entering_done", cpu_hold, 1);
    check("t3_ready_done", byte_ready, 0);
    cycles(1);
    check("t3_hold_released", cpu_hold, 0);
    // further bytes ignored
    rec_q = '{8'hA5, 8'h00, 8'h50, 8'h00, 8'h01, 8'h12, 8'h34};
    send_rec(1, 0);
    cycles(3);
    check("t3_still_done", loader_state, ST_DONE);
    check("t3_busy", loader_busy, 0);
    check("t3_hold_stays", cpu_hold, 0);
    check("t3_words", words_loaded, exp_wl);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
